// File: rtl/rm_lane_allocator_mp.sv
// -----------------------------------------------------------------------------
// rm_lane_allocator_mp
// Multi-port runtime-monitor lane allocator. Monitored loads/stores at issue
// are granted monitor lanes (lowest free lane to lowest monitored port, in
// order). Each lane walks FREE -> SPEC -> ACTIVE: commit promotes SPEC to
// ACTIVE, flush reclaims SPEC lanes, monitor events release lanes.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   opcode_i[j]          7-bit opcode of allocation port j
//   pc_i[j]              PC of allocation port j
//   entry_queued_i[j]    port j carries a valid instruction
//   mon_load_en_i        monitor load opcodes
//   mon_store_en_i       monitor store opcodes
//   reset_monitor[e]     release request e, packed {reset_lane, lane}
//   commit_valid_i[c]    commit strobe c
//   commit_lane_i[c]     lane committed by strobe c
//   flush_i              speculative flush
//   monitor_o[j]         grant to port j, packed {monitor_ins, lane}
//   stall_o[j]           monitored request on port j not granted
//   free_cnt_o           number of FREE lanes (registered state)
//   lane_pc_o[l]         PC held by lane l
//   illegal_rel_o        pulse: previous cycle committed/released a FREE lane
//   overflow_cnt_o       saturating count of stalled monitored requests
// -----------------------------------------------------------------------------
module rm_lane_allocator_mp #(
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned NUM_EVENTS = 10,
   parameter int unsigned NUM_ALLOC  = 2,
   parameter int unsigned NUM_COMMIT = 2,
   parameter int unsigned OVF_W      = 16,
   parameter int unsigned VLEN       = 64,
   localparam int unsigned LW        = $clog2(NUM_LANES),
   localparam int unsigned CW        = $clog2(NUM_LANES + 1)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NUM_ALLOC-1:0][6:0]            opcode_i,
   input  logic [NUM_ALLOC-1:0][VLEN-1:0]       pc_i,
   input  logic [NUM_ALLOC-1:0]                 entry_queued_i,
   input  logic                                 mon_load_en_i,
   input  logic                                 mon_store_en_i,
   input  logic [NUM_EVENTS-1:0][LW:0]          reset_monitor,
   input  logic [NUM_COMMIT-1:0]                commit_valid_i,
   input  logic [NUM_COMMIT-1:0][LW-1:0]        commit_lane_i,
   input  logic                                 flush_i,
   output logic [NUM_ALLOC-1:0][LW:0]           monitor_o,
   output logic [NUM_ALLOC-1:0]                 stall_o,
   output logic [CW-1:0]                        free_cnt_o,
   output logic [NUM_LANES-1:0][VLEN-1:0]       lane_pc_o,
   output logic                                 illegal_rel_o,
   output logic [OVF_W-1:0]                     overflow_cnt_o
);

   localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      L_FREE   = 2'd0,
      L_SPEC   = 2'd1,
      L_ACTIVE = 2'd2
   } lane_state_e;

   lane_state_e                      state_q [NUM_LANES];
   lane_state_e                      state_d [NUM_LANES];
   logic [NUM_LANES-1:0][VLEN-1:0]   pc_q, pc_d;
   logic [NUM_LANES-1:0][VLEN-1:0]   alloc_pc_s;
   logic [NUM_LANES-1:0]             rel_s, commit_s, avail_s, alloc_s, taken_s;
   logic [NUM_ALLOC-1:0]             mon_req_s;
   logic                             blocked_s, found_s;
   logic [LW-1:0]                    grant_lane_s;
   logic [CW-1:0]                    free_cnt_q, free_cnt_d;
   logic                             illegal_q, illegal_d;
   logic [OVF_W-1:0]                 ovf_q, ovf_d;
   logic [OVF_W:0]                   ovf_sum_s;

   // Decode release/commit targets and the per-port monitored request.
   always_comb begin
      rel_s     = '0;
      commit_s  = '0;
      mon_req_s = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         for (int e = 0; e < NUM_EVENTS; e++) begin
            if (reset_monitor[e][LW] && (reset_monitor[e][LW-1:0] == LW'(l))) begin
               rel_s[l] = 1'b1;
            end else begin
               rel_s[l] = rel_s[l];
            end
         end
         for (int c = 0; c < NUM_COMMIT; c++) begin
            if (commit_valid_i[c] && (commit_lane_i[c] == LW'(l))) begin
               commit_s[l] = 1'b1;
            end else begin
               commit_s[l] = commit_s[l];
            end
         end
         // A lane released this cycle is reusable in the same cycle.
         avail_s[l] = (state_q[l] == L_FREE) || rel_s[l];
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
         mon_req_s[j] = entry_queued_i[j] &&
                        (((opcode_i[j] == OPCODE_STORE) && mon_store_en_i) ||
                         ((opcode_i[j] == OPCODE_LOAD)  && mon_load_en_i));
      end
   end

   // In-order grant: once a monitored port misses, all later monitored ports stall.
   always_comb begin
      monitor_o    = '0;
      stall_o      = '0;
      alloc_s      = '0;
      alloc_pc_s   = '0;
      taken_s      = '0;
      blocked_s    = 1'b0;
      found_s      = 1'b0;
      grant_lane_s = '0;
      for (int j = 0; j < NUM_ALLOC; j++) begin
         found_s      = 1'b0;
         grant_lane_s = '0;
         if (flush_i || !mon_req_s[j]) begin
            stall_o[j] = 1'b0;
         end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
               if (!blocked_s && !found_s && avail_s[l] && !taken_s[l]) begin
                  found_s       = 1'b1;
                  grant_lane_s  = LW'(l);
                  taken_s[l]    = 1'b1;
                  alloc_s[l]    = 1'b1;
                  alloc_pc_s[l] = pc_i[j];
               end else begin
                  found_s = found_s;
               end
            end
            if (found_s) begin
               monitor_o[j] = {1'b1, grant_lane_s};
            end else begin
               blocked_s  = 1'b1;
               stall_o[j] = 1'b1;
            end
         end
      end
   end

   // Per-lane next state: allocation > commit > release > flush.
   always_comb begin
      illegal_d  = 1'b0;
      free_cnt_d = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         state_d[l] = state_q[l];
         pc_d[l]    = pc_q[l];
         if (alloc_s[l]) begin
            state_d[l] = L_SPEC;
            pc_d[l]    = alloc_pc_s[l];
         end else if (commit_s[l] && (state_q[l] == L_SPEC)) begin
            state_d[l] = L_ACTIVE;
         end else if (rel_s[l] && (state_q[l] != L_FREE)) begin
            state_d[l] = L_FREE;
            pc_d[l]    = '0;
         end else if (flush_i && (state_q[l] == L_SPEC)) begin
            state_d[l] = L_FREE;
            pc_d[l]    = '0;
         end else begin
            state_d[l] = state_q[l];
         end
         if ((commit_s[l] || rel_s[l]) && (state_q[l] == L_FREE) && !alloc_s[l]) begin
            illegal_d = 1'b1;
         end else begin
            illegal_d = illegal_d;
         end
         if (state_d[l] == L_FREE) begin
            free_cnt_d = free_cnt_d + CW'(1'b1);
         end else begin
            free_cnt_d = free_cnt_d;
         end
      end
   end

   // Saturating accumulation of stalled monitored requests.
   always_comb begin
      ovf_sum_s = {1'b0, ovf_q};
      for (int j = 0; j < NUM_ALLOC; j++) begin
         ovf_sum_s = ovf_sum_s + (OVF_W + 1)'(stall_o[j]);
      end
      if (ovf_sum_s[OVF_W]) begin
         ovf_d = '1;
      end else begin
         ovf_d = ovf_sum_s[OVF_W-1:0];
      end
   end

   // State, PC, count and statistic registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            state_q[l] <= L_FREE;
         end
         pc_q       <= '0;
         free_cnt_q <= CW'(NUM_LANES);
         illegal_q  <= 1'b0;
         ovf_q      <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            state_q[l] <= state_d[l];
         end
         pc_q       <= pc_d;
         free_cnt_q <= free_cnt_d;
         illegal_q  <= illegal_d;
         ovf_q      <= ovf_d;
      end
   end

   assign free_cnt_o     = free_cnt_q;
   assign lane_pc_o      = pc_q;
   assign illegal_rel_o  = illegal_q;
   assign overflow_cnt_o = ovf_q;

endmodule

// File: tb/tb_rm_lane_allocator_mp.sv
// -----------------------------------------------------------------------------
// Directed testbench for rm_lane_allocator_mp (default parameters).
// Expected grants are queued when a step is driven and popped when the
// combinational outputs are sampled; registered outputs are checked #1 after
// the following rising edge.
// -----------------------------------------------------------------------------
module tb_rm_lane_allocator_mp;

   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_STORE = 7'h23;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic [1:0][6:0]    opcode_i;
   logic [1:0][63:0]   pc_i;
   logic [1:0]         entry_queued_i;
   logic               mon_load_en_i;
   logic               mon_store_en_i;
   logic [9:0][2:0]    reset_monitor;
   logic [1:0]         commit_valid_i;
   logic [1:0][1:0]    commit_lane_i;
   logic               flush_i;
   logic [1:0][2:0]    monitor_o;
   logic [1:0]         stall_o;
   logic [2:0]         free_cnt_o;
   logic [3:0][63:0]   lane_pc_o;
   logic               illegal_rel_o;
   logic [15:0]        overflow_cnt_o;

   typedef struct packed {
      logic [1:0][2:0] mon;
      logic [1:0]      stall;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   rm_lane_allocator_mp dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .opcode_i       (opcode_i),
      .pc_i           (pc_i),
      .entry_queued_i (entry_queued_i),
      .mon_load_en_i  (mon_load_en_i),
      .mon_store_en_i (mon_store_en_i),
      .reset_monitor  (reset_monitor),
      .commit_valid_i (commit_valid_i),
      .commit_lane_i  (commit_lane_i),
      .flush_i        (flush_i),
      .monitor_o      (monitor_o),
      .stall_o        (stall_o),
      .free_cnt_o     (free_cnt_o),
      .lane_pc_o      (lane_pc_o),
      .illegal_rel_o  (illegal_rel_o),
      .overflow_cnt_o (overflow_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      opcode_i       = '0;
      pc_i           = '0;
      entry_queued_i = 2'b00;
      reset_monitor  = '0;
      commit_valid_i = 2'b00;
      commit_lane_i  = '0;
      flush_i        = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_exp(input logic [2:0] m0, input logic [2:0] m1, input logic [1:0] st);
      exp_t e;
      e.mon[0] = m0;
      e.mon[1] = m1;
      e.stall  = st;
      sb.push_back(e);
   endtask

   task automatic check_grant(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_mon0"},  64'(monitor_o[0]), 64'(e.mon[0]));
         chk({tag, "_mon1"},  64'(monitor_o[1]), 64'(e.mon[1]));
         chk({tag, "_stall"}, 64'(stall_o),      64'(e.stall));
      end
   endtask

   task automatic two_stores(input logic [63:0] p0, input logic [63:0] p1);
      opcode_i[0]    = OP_STORE;
      opcode_i[1]    = OP_STORE;
      pc_i[0]        = p0;
      pc_i[1]        = p1;
      entry_queued_i = 2'b11;
   endtask

   initial begin
      idle();
      mon_load_en_i  = 1'b0;
      mon_store_en_i = 1'b1;
      rst_ni         = 1'b0;
      #12;
      chk("rst_free",    64'(free_cnt_o),     64'd4);
      chk("rst_ovf",     64'(overflow_cnt_o), 64'd0);
      chk("rst_illegal", 64'(illegal_rel_o),  64'd0);
      chk("rst_pc0",     lane_pc_o[0],        64'd0);
      rst_ni = 1'b1;
      tick();

      // Two stores on an empty pool: lanes 0 and 1.
      two_stores(64'h1000, 64'h2000);
      push_exp(3'b100, 3'b101, 2'b00);
      #2 check_grant("A");
      tick();
      chk("A_free", 64'(free_cnt_o), 64'd2);
      chk("A_pc0",  lane_pc_o[0],    64'h1000);
      chk("A_pc1",  lane_pc_o[1],    64'h2000);

      // Fill lanes 2 and 3.
      two_stores(64'h3000, 64'h4000);
      push_exp(3'b110, 3'b111, 2'b00);
      #2 check_grant("B");
      tick();
      chk("B_free", 64'(free_cnt_o),     64'd0);
      chk("B_ovf",  64'(overflow_cnt_o), 64'd0);

      // Pool exhausted: both ports stall, statistic grows by 2 per cycle.
      two_stores(64'h7000, 64'h8000);
      push_exp(3'b000, 3'b000, 2'b11);
      #2 check_grant("C");
      tick();
      chk("C_ovf", 64'(overflow_cnt_o), 64'd2);
      for (int i = 0; i < 32766; i++) begin
         @(posedge clk_i);
      end
      #1;
      chk("C_ovf_fffe", 64'(overflow_cnt_o), 64'hFFFE);
      tick();
      chk("C_ovf_sat", 64'(overflow_cnt_o), 64'hFFFF);
      tick();
      chk("C_ovf_hold", 64'(overflow_cnt_o), 64'hFFFF);

      // Same-cycle reuse: release of lane 2 is granted to port0, port1 stalls.
      two_stores(64'h5000, 64'h6000);
      reset_monitor[3] = {1'b1, 2'd2};
      push_exp(3'b110, 3'b000, 2'b10);
      #2 check_grant("D");
      tick();
      chk("D_free",    64'(free_cnt_o),     64'd0);
      chk("D_pc2",     lane_pc_o[2],        64'h5000);
      chk("D_ovf",     64'(overflow_cnt_o), 64'hFFFF);
      chk("D_illegal", 64'(illegal_rel_o),  64'd0);

      // Release lane 3 so that lanes 0..2 are the only SPEC lanes.
      idle();
      reset_monitor[0] = {1'b1, 2'd3};
      tick();
      chk("R3_free", 64'(free_cnt_o), 64'd1);
      chk("R3_pc3",  lane_pc_o[3],    64'd0);

      // Commit lane 1 with flush: lane 1 ACTIVE, lanes 0/2 reclaimed, no grants.
      idle();
      opcode_i[0]       = OP_STORE;
      pc_i[0]           = 64'h9000;
      entry_queued_i    = 2'b01;
      commit_valid_i[0] = 1'b1;
      commit_lane_i[0]  = 2'd1;
      flush_i           = 1'b1;
      push_exp(3'b000, 3'b000, 2'b00);
      #2 check_grant("E");
      tick();
      chk("E_free",    64'(free_cnt_o),    64'd3);
      chk("E_pc0",     lane_pc_o[0],       64'd0);
      chk("E_pc1",     lane_pc_o[1],       64'h2000);
      chk("E_pc2",     lane_pc_o[2],       64'd0);
      chk("E_illegal", 64'(illegal_rel_o), 64'd0);

      // Release of FREE lane 3: one-cycle illegal pulse, state unchanged.
      idle();
      reset_monitor[5] = {1'b1, 2'd3};
      tick();
      chk("F_illegal", 64'(illegal_rel_o), 64'd1);
      chk("F_free",    64'(free_cnt_o),    64'd3);
      idle();
      tick();
      chk("F_illegal_clr", 64'(illegal_rel_o), 64'd0);
      chk("F_pc1",         lane_pc_o[1],       64'h2000);

      // Unmonitored load on port0, store on port1 gets lane 0; then async reset.
      opcode_i[0]    = OP_LOAD;
      opcode_i[1]    = OP_STORE;
      pc_i[0]        = 64'hA000;
      pc_i[1]        = 64'hB000;
      entry_queued_i = 2'b11;
      push_exp(3'b000, 3'b100, 2'b00);
      #2 check_grant("G");
      #1 rst_ni = 1'b0;
      #1;
      chk("G_rst_free",    64'(free_cnt_o),     64'd4);
      chk("G_rst_ovf",     64'(overflow_cnt_o), 64'd0);
      chk("G_rst_pc1",     lane_pc_o[1],        64'd0);
      chk("G_rst_illegal", 64'(illegal_rel_o),  64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rm_lane_allocator_mp.md
Name: rm_lane_allocator_mp

Overview:
- Multi-port, parametrised successor to the single-port runtime-monitor lane allocator.
- Allocates monitor lanes to up to NUM_ALLOC instructions per cycle at issue, selected by a runtime-configurable opcode class mask.
- Tracks each lane through FREE -> SPEC -> ACTIVE. Commit moves SPEC to ACTIVE; flush reclaims speculative lanes; monitor events release lanes.
- Provides per-port backpressure, a free-lane count and a saturating overflow statistic.

Parameters:
- NUM_LANES, 4: number of monitor lanes (>=2).
- NUM_EVENTS, 10: number of event-driven release requests per cycle.
- NUM_ALLOC, 2: allocation ports per cycle (1..NUM_LANES).
- NUM_COMMIT, 2: commit ports per cycle.
- OVF_W, 16: overflow counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- opcode_i  in  NUM_ALLOC x 7  opcode per allocation port.
- pc_i  in  NUM_ALLOC x riscv::VLEN  PC per allocation port.
- entry_queued_i  in  NUM_ALLOC  valid per port.
- mon_load_en_i  in  1  monitor riscv::OpcodeLoad.
- mon_store_en_i  in  1  monitor riscv::OpcodeStore.
- reset_monitor  in  NUM_EVENTS x ariane_pkg::lane_ctrl  event release requests (reset_lane, lane).
- commit_valid_i  in  NUM_COMMIT  commit strobe.
- commit_lane_i  in  NUM_COMMIT x $clog2(NUM_LANES)  committed lane.
- flush_i  in  1  speculative flush.
- monitor_o  out  NUM_ALLOC x ariane_pkg::runtime_monitor_ctrl  grant (monitor_ins, lane).
- stall_o  out  NUM_ALLOC  monitored request not granted this cycle.
- free_cnt_o  out  $clog2(NUM_LANES+1)  number of lanes in state FREE (registered state).
- lane_pc_o  out  NUM_LANES x riscv::VLEN  PC held per lane.
- illegal_rel_o  out  1  one-cycle pulse: commit/release targeted a FREE lane.
- overflow_cnt_o  out  OVF_W  saturating count of stalled monitored requests.

Behaviour:
- Reset (async, rst_ni low): all lanes FREE, lane_pc_o=0, overflow_cnt_o=0, illegal_rel_o=0, free_cnt_o=NUM_LANES.
- Monitored request on port j: entry_queued_i[j] && ((opcode==OpcodeStore && mon_store_en_i) || (opcode==OpcodeLoad && mon_load_en_i)).
- Available set (combinational) = lanes FREE in state, plus lanes released this cycle by any reset_monitor entry (same-cycle reuse).
- Grant order: lowest-index available lane to the lowest-index monitored port, next lowest to the next, and so on.
- In-order grants: if monitored port j is not granted, every monitored port k>j is also not granted (stall_o[k]=1).
- Unmonitored ports: monitor_o.monitor_ins=0, lane=0, stall_o=0.
- Granted port: monitor_o.monitor_ins=1, lane=granted index, same cycle (combinational).
- Stalled port: monitor_o.monitor_ins=0, lane=0, stall_o=1.
- flush_i=1: no grants (all monitor_ins=0, stall_o=0). At the clock edge every SPEC lane goes FREE and its PC clears.
- Per-lane next state, applied in this priority order:
  1. Allocation: -> SPEC and PC latched. Wins over a same-cycle release of the same lane.
  2. Commit: SPEC->ACTIVE. Commit beats flush.
  3. Release (reset_monitor reset_lane): SPEC/ACTIVE -> FREE, PC cleared.
  4. Flush: SPEC -> FREE.
- Commit of an ACTIVE lane: no effect.
- Commit or release targeting a FREE lane (not allocated the same cycle): state unchanged; illegal_rel_o=1 on the next cycle.
- Duplicate releases of one lane in the same cycle: idempotent.
- overflow_cnt_o: at each edge, adds the number of ports with stall_o=1. Saturates at all-ones with no wrap.
- free_cnt_o reflects registered state only; it excludes same-cycle releases.

Test Plan:
- Reset, then store on port0 and store on port1 with mon_store_en_i=1: lanes 0 and 1 granted; next cycle free_cnt_o=2 and lane_pc_o[0..1] hold the PCs.
- All 4 lanes SPEC, two stores presented: stall_o=2'b11 and no grants; overflow_cnt_o increments by 2 per cycle; after being forced to 0xFFFE it ends at 0xFFFF.
- All lanes full, reset_monitor[3] releases lane 2 while a store arrives on port0: port0 granted lane 2 the same cycle; port1 store stalls.
- Lanes 0–2 SPEC, commit lane 1 together with flush_i: lane 1 goes ACTIVE, lanes 0 and 2 FREE; free_cnt_o=3; no grants during the flush cycle.
- Release of FREE lane 3: state unchanged; illegal_rel_o pulses for exactly 1 cycle.
- Load on port0 with mon_load_en_i=0 and store on port1: port0 unmonitored, port1 granted lane 0. Assert rst_ni low mid-traffic: all outputs return to reset values immediately.
